sdram_wb_master: RTL and testbench

- Wishbone classic-cycle initiator that drives the SDRAM controller's slave port, which is checked by the cyc/stb/ack assertion interface.
- Accepts single or burst read/write commands from the test/traffic layer over a valid/ready handshake.
- Issues one Wishbone beat per word with an incrementing address, returns read data, and flags ack timeouts.

---
 rtl/sdram_wb_master.sv | 170 +++++++++++++++++
 tb/tb_sdram_wb_master.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_wb_master.sv
// sdram_wb_master: Wishbone classic-cycle initiator for the SDRAM slave port.
// Runs single or burst read/write commands, one beat per word, with ack timeout.
module sdram_wb_master #(
  parameter int AW      = 24,
  parameter int DW      = 32,
  parameter int LW      = 4,
  parameter int TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_we_i,
  input  logic [AW-1:0]   cmd_addr_i,
  input  logic [LW-1:0]   cmd_len_i,
  input  logic            wr_valid_i,
  input  logic [DW-1:0]   wr_data_i,
  output logic            wr_ready_o,
  output logic            rd_valid_o,
  output logic [DW-1:0]   rd_data_o,
  output logic            done_o,
  output logic            err_o,
  output logic            cyc_o,
  output logic            stb_o,
  output logic            we_o,
  output logic [AW-1:0]   adr_o,
  output logic [DW-1:0]   dat_o,
  output logic [DW/8-1:0] sel_o,
  input  logic [DW-1:0]   dat_i,
  input  logic            ack_i
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    STROBE,
    NEXT
  } state_e;

  state_e          state_q;
  logic            rdy_q;
  logic            wrr_q;
  logic            cyc_q;
  logic            stb_q;
  logic            we_q;
  logic [AW-1:0]   adr_q;
  logic [DW-1:0]   dat_q;
  logic            rdv_q;
  logic [DW-1:0]   rdd_q;
  logic            done_q;
  logic            err_q;
  logic [LW-1:0]   len_q;
  logic [LW-1:0]   beat_q;
  logic [TW-1:0]   tmo_q;

  logic            last_beat_d;
  logic            tmo_hit_d;

  assign last_beat_d = (beat_q == len_q);
  assign tmo_hit_d   = (tmo_q == TW'(TIMEOUT - 1));

  assign cmd_ready_o = rdy_q;
  assign wr_ready_o  = wrr_q;
  assign cyc_o       = cyc_q;
  assign stb_o       = stb_q;
  assign we_o        = we_q;
  assign adr_o       = adr_q;
  assign dat_o       = dat_q;
  assign sel_o       = {(DW/8){stb_q}};
  assign rd_valid_o  = rdv_q;
  assign rd_data_o   = rdd_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

  // Burst sequencer: all bus and handshake outputs are registered here.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      wrr_q   <= 1'b0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      rdv_q   <= 1'b0;
      rdd_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      len_q   <= '0;
      beat_q  <= '0;
      tmo_q   <= '0;
    end else begin
      rdv_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (rdy_q && cmd_valid_i) begin
            rdy_q  <= 1'b0;
            we_q   <= cmd_we_i;
            adr_q  <= cmd_addr_i;
            len_q  <= cmd_len_i;
            beat_q <= '0;
            tmo_q  <= '0;
            if (cmd_we_i) begin
              wrr_q   <= 1'b1;
              state_q <= FETCH;
            end else begin
              cyc_q   <= 1'b1;
              stb_q   <= 1'b1;
              state_q <= STROBE;
            end
          end else begin
            rdy_q <= 1'b1;
          end
        end
        FETCH: begin
          if (wrr_q && wr_valid_i) begin
            wrr_q   <= 1'b0;
            dat_q   <= wr_data_i;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            state_q <= STROBE;
          end
        end
        STROBE: begin
          tmo_q <= tmo_q + TW'(1);
          if (ack_i) begin
            stb_q <= 1'b0;
            if (!we_q) begin
              rdd_q <= dat_i;
              rdv_q <= 1'b1;
            end
            if (last_beat_d) begin
              cyc_q   <= 1'b0;
              done_q  <= 1'b1;
              rdy_q   <= 1'b1;
              state_q <= IDLE;
            end else begin
              state_q <= NEXT;
            end
          end else if (tmo_hit_d) begin
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            err_q   <= 1'b1;
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        NEXT: begin
          adr_q  <= adr_q + AW'(1);
          beat_q <= beat_q + LW'(1);
          tmo_q  <= '0;
          if (we_q) begin
            wrr_q   <= 1'b1;
            state_q <= FETCH;
          end else begin
            stb_q   <= 1'b1;
            state_q <= STROBE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_wb_master.sv
// tb_sdram_wb_master: randomized bench for sdram_wb_master against a
// beat-level reference model and a behavioural Wishbone slave.
module tb_sdram_wb_master;
  localparam int AW  = 24;
  localparam int DW  = 32;
  localparam int LW  = 4;
  localparam int TMO = 8;

  logic          clk_i       = 1'b0;
  logic          rst_i       = 1'b0;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic          cmd_we_i    = 1'b0;
  logic [AW-1:0] cmd_addr_i  = '0;
  logic [LW-1:0] cmd_len_i   = '0;
  logic          wr_valid_i  = 1'b0;
  logic [DW-1:0] wr_data_i   = '0;
  logic          wr_ready_o;
  logic          rd_valid_o;
  logic [DW-1:0] rd_data_o;
  logic          done_o;
  logic          err_o;
  logic          cyc_o;
  logic          stb_o;
  logic          we_o;
  logic [AW-1:0] adr_o;
  logic [DW-1:0] dat_o;
  logic [3:0]    sel_o;
  logic [DW-1:0] dat_i       = '0;
  logic          ack_i       = 1'b0;

  sdram_wb_master #(.AW(AW), .DW(DW), .LW(LW), .TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_we_i(cmd_we_i), .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
    .wr_valid_i(wr_valid_i), .wr_data_i(wr_data_i), .wr_ready_o(wr_ready_o),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
    .done_o(done_o), .err_o(err_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
    .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o),
    .dat_i(dat_i), .ack_i(ack_i)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  logic [31:0] salt = 32'h0;
  int          dly_a[17];
  logic [31:0] wd_a[16];
  logic [31:0] wr_q[$];
  bit          gap_en  = 1'b0;
  bit          spur_en = 1'b0;
  int          bidx    = 0;
  int          scnt    = 0;
  bit          ack_real = 1'b0;

  int cyc_n = 0, acc_cyc = -1, first_stb = -1, first_ack = -1, first_rdv = -1;
  int stb_cnt = 0, done_cnt = 0, err_cnt = 0, wr_hs = 0;
  int cyc_rise = 0, cyc_fall = 0, inv_err = 0;
  logic [23:0] adr_log[$];
  logic        we_log[$];
  logic [31:0] dat_log[$];
  logic [31:0] rd_log[$];
  logic cyc_p = 1'b0, stb_p = 1'b0, rst_p = 1'b0;

  function automatic logic [31:0] rdword(input logic [23:0] a);
    return {8'h5A, a} ^ salt;
  endfunction

  // Wishbone slave: acks the n-th strobe cycle of each beat, n from dly_a.
  initial forever begin
    @(posedge clk_i);
    #1;
    if (ack_i && ack_real && bidx < 16) bidx++;
    if (stb_o) scnt++;
    else scnt = 0;
    if (stb_o && dly_a[bidx] != 0 && scnt == dly_a[bidx]) begin
      ack_i    = 1'b1;
      ack_real = 1'b1;
      dat_i    = rdword(adr_o);
    end else begin
      ack_real = 1'b0;
      ack_i    = (!stb_o && spur_en) ? 1'($urandom_range(0, 1)) : 1'b0;
      dat_i    = $urandom;
    end
  end

  // Write-data source with optional random gaps.
  initial forever begin
    @(posedge clk_i);
    #1;
    if (wr_q.size() > 0 && (!gap_en || $urandom_range(0, 2) != 0)) begin
      wr_valid_i = 1'b1;
      wr_data_i  = wr_q[0];
    end else begin
      wr_valid_i = 1'b0;
      wr_data_i  = $urandom;
    end
  end

  // Monitor, sampling mid-cycle.
  initial forever begin
    @(negedge clk_i);
    cyc_n++;
    if (rst_i && rst_p) begin
      if (stb_o && !cyc_o) inv_err++;
      if (stb_o && sel_o != 4'hF) inv_err++;
      if (done_o && err_o) inv_err++;
      if (cyc_o && !cyc_p) begin
        cyc_rise++;
        if (!stb_o) inv_err++;
      end
      if (!cyc_o && cyc_p) begin
        cyc_fall++;
        if (!stb_p) inv_err++;
      end
    end
    if (rst_i) begin
      if (cmd_valid_i && cmd_ready_o) acc_cyc = cyc_n;
      if (stb_o) begin
        stb_cnt++;
        if (first_stb < 0) first_stb = cyc_n;
      end
      if (stb_o && ack_i) begin
        adr_log.push_back(adr_o);
        we_log.push_back(we_o);
        dat_log.push_back(dat_o);
        if (first_ack < 0) first_ack = cyc_n;
      end
      if (rd_valid_o) begin
        rd_log.push_back(rd_data_o);
        if (first_rdv < 0) first_rdv = cyc_n;
      end
      if (done_o) done_cnt++;
      if (err_o) err_cnt++;
      if (wr_valid_i && wr_ready_o) begin
        wr_hs++;
        if (wr_q.size() > 0) void'(wr_q.pop_front());
      end
    end
    cyc_p = cyc_o;
    stb_p = stb_o;
    rst_p = rst_i;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  task automatic clear_logs();
    adr_log.delete();
    we_log.delete();
    dat_log.delete();
    rd_log.delete();
    first_stb = -1;
    first_ack = -1;
    first_rdv = -1;
    stb_cnt   = 0;
    done_cnt  = 0;
    err_cnt   = 0;
    wr_hs     = 0;
    cyc_rise  = 0;
    cyc_fall  = 0;
    bidx      = 0;
  endtask

  task automatic issue(input logic we, input logic [23:0] a, input logic [3:0] l);
    int n;
    n = 0;
    @(posedge clk_i);
    #1;
    acc_cyc     = -1;
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_addr_i  = a;
    cmd_len_i   = l;
    while (acc_cyc < 0 && n < 50) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    checks++;
    if (acc_cyc < 0) begin
      failures++;
      $display("FAIL accept: cmd_ready_o got 0 want 1 within 50 cycles");
    end
    @(posedge clk_i);
    #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (done_cnt + err_cnt == 0 && n < 600) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    checks++;
    if (done_cnt + err_cnt == 0) begin
      failures++;
      $display("FAIL end_wait: done/err got none want one within 600 cycles");
    end
    repeat (2) begin
      @(negedge clk_i);
      #1;
    end
  endtask

  // Run one command and compare against the beat-level model.
  task automatic run_and_check(input logic we, input logic [23:0] a,
                               input logic [3:0] l, input string nm);
    int ab, n_ok, issued, exp_stb, nb;
    logic [23:0] ea;
    clear_logs();
    wr_q.delete();
    nb = int'(l) + 1;
    if (we) for (int i = 0; i < nb; i++) wr_q.push_back(wd_a[i]);
    issue(we, a, l);
    wait_end();
    ab = -1;
    exp_stb = 0;
    for (int i = 0; i < nb; i++) begin
      if (dly_a[i] == 0 || dly_a[i] > TMO) begin
        ab = i;
        exp_stb += TMO;
        break;
      end
      exp_stb += dly_a[i];
    end
    n_ok   = (ab < 0) ? nb : ab;
    issued = (ab < 0) ? nb : ab + 1;
    checks++;
    if (adr_log.size() != n_ok) begin
      failures++;
      $display("FAIL %s beats: got %0d want %0d", nm, adr_log.size(), n_ok);
    end
    for (int i = 0; i < n_ok && i < adr_log.size(); i++) begin
      ea = a + 24'(i);
      checks++;
      if (adr_log[i] !== ea || we_log[i] !== we) begin
        failures++;
        $display("FAIL %s beat%0d adr/we: got %h/%b want %h/%b",
                 nm, i, adr_log[i], we_log[i], ea, we);
      end
      if (we) begin
        checks++;
        if (dat_log[i] !== wd_a[i]) begin
          failures++;
          $display("FAIL %s beat%0d dat_o: got %h want %h", nm, i, dat_log[i], wd_a[i]);
        end
      end
    end
    checks++;
    if (rd_log.size() != (we ? 0 : n_ok)) begin
      failures++;
      $display("FAIL %s rd_count: got %0d want %0d", nm, rd_log.size(), we ? 0 : n_ok);
    end
    for (int i = 0; i < rd_log.size() && !we && i < n_ok; i++) begin
      ea = a + 24'(i);
      checks++;
      if (rd_log[i] !== rdword(ea)) begin
        failures++;
        $display("FAIL %s rd%0d: got %h want %h", nm, i, rd_log[i], rdword(ea));
      end
    end
    checks++;
    if (done_cnt != (ab < 0 ? 1 : 0) || err_cnt != (ab < 0 ? 0 : 1)) begin
      failures++;
      $display("FAIL %s done/err: got %0d/%0d want %0d/%0d", nm,
               done_cnt, err_cnt, ab < 0 ? 1 : 0, ab < 0 ? 0 : 1);
    end
    checks++;
    if (stb_cnt != exp_stb) begin
      failures++;
      $display("FAIL %s stb_cycles: got %0d want %0d", nm, stb_cnt, exp_stb);
    end
    checks++;
    if (wr_hs != (we ? issued : 0) || wr_q.size() != (we ? nb - issued : 0)) begin
      failures++;
      $display("FAIL %s wr_hs/left: got %0d/%0d want %0d/%0d", nm, wr_hs,
               wr_q.size(), we ? issued : 0, we ? nb - issued : 0);
    end
    checks++;
    if (cyc_rise != 1 || cyc_fall != 1) begin
      failures++;
      $display("FAIL %s cyc_edges: got rise %0d fall %0d want 1 1", nm, cyc_rise, cyc_fall);
    end
    checks++;
    if (cmd_ready_o !== 1'b1 || cyc_o !== 1'b0) begin
      failures++;
      $display("FAIL %s idle_after: got ready %b cyc %b want 1 0", nm, cmd_ready_o, cyc_o);
    end
    checks++;
    if (inv_err != 0) begin
      failures++;
      $display("FAIL %s invariants: got %0d violations want 0", nm, inv_err);
      inv_err = 0;
    end
    if (!we) begin
      checks++;
      if (first_stb - acc_cyc != 1) begin
        failures++;
        $display("FAIL %s acc_to_stb: got %0d want 1", nm, first_stb - acc_cyc);
      end
      if (n_ok > 0) begin
        checks++;
        if (first_rdv - first_ack != 1) begin
          failures++;
          $display("FAIL %s ack_to_rdv: got %0d want 1", nm, first_rdv - first_ack);
        end
      end
    end
    wr_q.delete();
  endtask

  task automatic test_reset();
    logic [4:0] ctl;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    #1;
    ctl = {cmd_ready_o, wr_ready_o, cyc_o, stb_o, we_o};
    checks++;
    if (ctl !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctl: got %b want 00000", ctl);
    end
    checks++;
    if ({adr_o, dat_o, sel_o, rd_data_o} !== '0 ||
        {rd_valid_o, done_o, err_o} !== 3'b0) begin
      failures++;
      $display("FAIL reset_data: got adr %h dat %h rdv %b want all 0", adr_o, dat_o, rd_valid_o);
    end
    rst_i = 1'b1;
    @(negedge clk_i);
    #1;
    checks++;
    if (cmd_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_release: cmd_ready_o got %b want 1", cmd_ready_o);
    end
  endtask

  task automatic test_single_read();
    salt = 32'hDEADBEEF ^ {8'h5A, 24'h000010};
    dly_a[0] = 2;
    run_and_check(1'b0, 24'h000010, 4'd0, "single_read");
    checks++;
    if (rd_log.size() != 1 || rd_log[0] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL single_read_data: got %h want deadbeef",
               rd_log.size() > 0 ? rd_log[0] : 32'h0);
    end
  endtask

  task automatic test_write_burst();
    gap_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wd_a[i]  = 32'(i + 1);
      dly_a[i] = 1;
    end
    run_and_check(1'b1, 24'h000100, 4'd3, "write_burst");
  endtask

  task automatic test_addr_wrap();
    for (int i = 0; i < 4; i++) dly_a[i] = 1;
    run_and_check(1'b0, 24'hFFFFFE, 4'd3, "addr_wrap");
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 3; i++) dly_a[i] = 0;
    run_and_check(1'b0, 24'h000200, 4'd2, "timeout");
  endtask

  task automatic test_ack_race();
    dly_a[0] = TMO;
    run_and_check(1'b0, 24'h000300, 4'd0, "ack_race");
  endtask

  task automatic test_reset_mid_burst();
    int n;
    clear_logs();
    wr_q.delete();
    for (int i = 0; i < 4; i++) begin
      dly_a[i] = 1;
      wr_q.push_back(32'hA000 + 32'(i));
    end
    issue(1'b1, 24'h000040, 4'd3);
    n = 0;
    while (!(bidx == 1 && stb_o) && n < 100) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    checks++;
    if (!(bidx == 1 && stb_o)) begin
      failures++;
      $display("FAIL rst_mid_reach: second beat strobe got 0 want 1");
    end
    rst_i = 1'b0;
    #1;
    checks++;
    if ({cyc_o, stb_o, wr_ready_o, cmd_ready_o} !== 4'b0 ||
        {done_o, err_o, rd_valid_o} !== 3'b0) begin
      failures++;
      $display("FAIL rst_mid_async: got cyc %b stb %b wrr %b want 0 0 0", cyc_o, stb_o, wr_ready_o);
    end
    wr_q.delete();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    #1;
    rst_i = 1'b1;
    @(negedge clk_i);
    #1;
    checks++;
    if (cmd_ready_o !== 1'b1 || done_cnt != 0 || err_cnt != 0) begin
      failures++;
      $display("FAIL rst_mid_after: got ready %b done %0d err %0d want 1 0 0",
               cmd_ready_o, done_cnt, err_cnt);
    end
    dly_a[0] = 1;
    run_and_check(1'b0, 24'h000020, 4'd0, "rst_fresh_read");
  endtask

  task automatic test_random();
    logic        we;
    logic [23:0] a;
    logic [3:0]  l;
    gap_en  = 1'b1;
    spur_en = 1'b1;
    salt    = $urandom;
    for (int c = 0; c < 24; c++) begin
      we = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? 24'hFFFFF0 + 24'($urandom_range(0, 15))
                                       : 24'($urandom);
      l  = 4'($urandom_range(0, 15));
      for (int i = 0; i < 16; i++) begin
        dly_a[i] = $urandom_range(1, TMO);
        wd_a[i]  = $urandom;
      end
      if ($urandom_range(0, 5) == 0)
        dly_a[$urandom_range(0, int'(l))] = ($urandom_range(0, 1) == 0) ? 0 : TMO + 1;
      run_and_check(we, a, l, "random");
    end
  endtask

  initial begin
    for (int i = 0; i < 17; i++) dly_a[i] = 1;
    for (int i = 0; i < 16; i++) wd_a[i] = 32'h0;
    test_reset();
    test_single_read();
    test_write_burst();
    test_addr_wrap();
    test_timeout();
    test_ack_race();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
